// File: rtl/uart_pattern_checker.sv
// Loopback self-test engine: drives a pattern into the UART driver's TX interface and
// checks every word returned on RX against an in-flight FIFO of expected words.
module uart_pattern_checker #(
    parameter int P_DATA_WIDTH     = 8,
    parameter int P_FIFO_DEPTH     = 4,
    parameter int P_CNT_WIDTH      = 16,
    parameter int P_TIMEOUT_CYCLES = 200000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_mode,
    input  logic [P_CNT_WIDTH-1:0]  i_burst_len,
    output logic [P_DATA_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    input  logic [P_DATA_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [P_CNT_WIDTH-1:0]  o_tx_count,
    output logic [P_CNT_WIDTH-1:0]  o_rx_count,
    output logic [P_CNT_WIDTH-1:0]  o_err_count,
    output logic                    o_unexpected,
    output logic                    o_timeout
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(P_TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0]            LFSR_SEED  = 16'hACE1;
    localparam logic [IW-1:0]          IDLE_LIMIT = IW'(P_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]          FIFO_FULL  = CW'(P_FIFO_DEPTH);
    localparam logic [P_CNT_WIDTH-1:0] CNT_ZERO   = {P_CNT_WIDTH{1'b0}};
    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX    = {P_CNT_WIDTH{1'b1}};

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [1:0]              state_q, state_d;
    logic                    mode_q, mode_d;
    logic [P_CNT_WIDTH-1:0]  burst_q, burst_d;
    logic [P_DATA_WIDTH-1:0] val_q, val_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                    stop_q, stop_d;
    logic [P_DATA_WIDTH-1:0] fifo_q [P_FIFO_DEPTH];
    logic [P_DATA_WIDTH-1:0] fifo_d [P_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d, count_step_s;
    logic [P_CNT_WIDTH-1:0]  tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic [P_CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic                    unexpected_q, unexpected_d, timeout_q, timeout_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic                    hs_s, hold_s, busy_s, rx_fire_s, fifo_empty_s, pop_s;
    logic                    err_inc_s, timeout_hit_s, stop_req_s, burst_hit_s;
    logic [P_DATA_WIDTH-1:0] head_s;

    assign hs_s          = tx_valid_q & i_tx_ready;
    assign hold_s        = tx_valid_q & ~i_tx_ready;
    assign busy_s        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign rx_fire_s     = i_rx_valid & busy_s;
    assign fifo_empty_s  = (count_q == {CW{1'b0}});
    assign pop_s         = rx_fire_s & ~fifo_empty_s;
    assign head_s        = fifo_q[rd_ptr_q];
    assign err_inc_s     = rx_fire_s & (fifo_empty_s | (head_s != i_rx_data));
    assign timeout_hit_s = busy_s & ~fifo_empty_s & ~rx_fire_s & (idle_q == IDLE_LIMIT);
    assign stop_req_s    = i_stop | stop_q;

    // Expected-word FIFO write port.
    always_comb begin
        fifo_d = fifo_q;
        if (hs_s) begin
            fifo_d[wr_ptr_q] = tx_data_q;
        end else begin
            fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
        end
    end

    // Occupancy step; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({hs_s, pop_s})
            2'b10:   count_step_s = count_q + CW'(1'b1);
            2'b01:   count_step_s = count_q - CW'(1'b1);
            default: count_step_s = count_q;
        endcase
    end

    // Sequencer, generator, counters and status next-state.
    always_comb begin
        tx_count_d   = hs_s ? tx_count_q + P_CNT_WIDTH'(1'b1) : tx_count_q;
        rx_count_d   = rx_fire_s ? rx_count_q + P_CNT_WIDTH'(1'b1) : rx_count_q;
        err_count_d  = (err_inc_s && (err_count_q != CNT_MAX)) ? err_count_q + P_CNT_WIDTH'(1'b1)
                                                               : err_count_q;
        unexpected_d = unexpected_q | (rx_fire_s & fifo_empty_s);
        timeout_d    = timeout_q | timeout_hit_s;
        val_d        = hs_s ? val_q + P_DATA_WIDTH'(1'b1) : val_q;
        lfsr_d       = hs_s ? lfsr_step(lfsr_q) : lfsr_q;
        wr_ptr_d     = timeout_hit_s ? {AW{1'b0}} : (hs_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q);
        rd_ptr_d     = timeout_hit_s ? {AW{1'b0}} : (pop_s ? rd_ptr_q + AW'(1'b1) : rd_ptr_q);
        count_d      = timeout_hit_s ? {CW{1'b0}} : count_step_s;
        idle_d       = (rx_fire_s || fifo_empty_s || !busy_s || timeout_hit_s) ? {IW{1'b0}}
                                                                               : idle_q + IW'(1'b1);
        burst_hit_s  = (burst_q != CNT_ZERO) && (tx_count_d == burst_q);
        state_d      = state_q;
        mode_d       = mode_q;
        burst_d      = burst_q;
        tx_valid_d   = tx_valid_q;
        stop_d       = stop_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d      = S_RUN;
                    mode_d       = i_mode;
                    burst_d      = i_burst_len;
                    val_d        = {P_DATA_WIDTH{1'b0}};
                    lfsr_d       = LFSR_SEED;
                    tx_valid_d   = 1'b0;
                    stop_d       = 1'b0;
                    wr_ptr_d     = {AW{1'b0}};
                    rd_ptr_d     = {AW{1'b0}};
                    count_d      = {CW{1'b0}};
                    tx_count_d   = CNT_ZERO;
                    rx_count_d   = CNT_ZERO;
                    err_count_d  = CNT_ZERO;
                    unexpected_d = 1'b0;
                    timeout_d    = 1'b0;
                    idle_d       = {IW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (timeout_hit_s) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    stop_d     = 1'b0;
                end else if (burst_hit_s || (stop_req_s && !hold_s)) begin
                    state_d    = S_DRAIN;
                    tx_valid_d = 1'b0;
                    stop_d     = 1'b0;
                end else if (stop_req_s) begin
                    // A pending word is never withdrawn; finish it before draining.
                    stop_d     = 1'b1;
                    tx_valid_d = 1'b1;
                end else begin
                    tx_valid_d = hold_s || (count_d < FIFO_FULL);
                end
            end
            S_DRAIN: begin
                if (timeout_hit_s || (count_d == {CW{1'b0}})) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        tx_data_d = hold_s ? tx_data_q : (mode_d ? lfsr_d[P_DATA_WIDTH-1:0] : val_d);
        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        pass_d    = done_d && (err_count_d == CNT_ZERO) && !unexpected_d && !timeout_d;
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            burst_q      <= CNT_ZERO;
            val_q        <= {P_DATA_WIDTH{1'b0}};
            lfsr_q       <= LFSR_SEED;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= {P_DATA_WIDTH{1'b0}};
            stop_q       <= 1'b0;
            for (int i = 0; i < P_FIFO_DEPTH; i++) begin
                fifo_q[i] <= {P_DATA_WIDTH{1'b0}};
            end
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            tx_count_q   <= CNT_ZERO;
            rx_count_q   <= CNT_ZERO;
            err_count_q  <= CNT_ZERO;
            unexpected_q <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= {IW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            burst_q      <= burst_d;
            val_q        <= val_d;
            lfsr_q       <= lfsr_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            stop_q       <= stop_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_count_q   <= tx_count_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            unexpected_q <= unexpected_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_tx_count   = tx_count_q;
    assign o_rx_count   = rx_count_q;
    assign o_err_count  = err_count_q;
    assign o_unexpected = unexpected_q;
    assign o_timeout    = timeout_q;

endmodule

// File: doc/uart_pattern_checker.md
Name: uart_pattern_checker

Overview:
Synthesizable loopback self-test engine for the UART driver. It generates a data pattern onto the driver's user TX valid/ready interface and tracks every accepted word in an expected-data FIFO. Each word returned on the driver's user RX interface is compared against the FIFO head, and the engine reports counts, errors and a timeout. It replaces free-running stimulus logic with a bounded, self-checking, parametrised block usable on silicon.

Parameters:
P_DATA_WIDTH, 8, user word width (1..16).
P_FIFO_DEPTH, 4, maximum words in flight (TX accepted, RX not yet returned); power of 2, at least 2.
P_CNT_WIDTH, 16, width of the burst length and all counters.
P_TIMEOUT_CYCLES, 200000, idle clocks allowed with words outstanding before timeout.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_start  input  1  single-cycle pulse; starts a run from IDLE or DONE
i_stop  input  1  single-cycle pulse; stops generation, then drains
i_mode  input  1  0 = incrementing pattern, 1 = LFSR pattern
i_burst_len  input  P_CNT_WIDTH  words per run; 0 = continuous until i_stop
o_tx_data  output  P_DATA_WIDTH  word to the UART driver
o_tx_valid  output  1  o_tx_data is valid
i_tx_ready  input  1  driver accepts the word when high together with o_tx_valid
i_rx_data  input  P_DATA_WIDTH  word received by the driver
i_rx_valid  input  1  single-cycle strobe for i_rx_data
o_busy  output  1  high in RUN or DRAIN
o_done  output  1  high in DONE
o_pass  output  1  high in DONE when the error count is 0, the unexpected flag is clear and the timeout flag is clear
o_tx_count  output  P_CNT_WIDTH  words accepted by the driver
o_rx_count  output  P_CNT_WIDTH  words received
o_err_count  output  P_CNT_WIDTH  mismatches plus unexpected words; saturates at all-ones
o_unexpected  output  1  sticky; a word was received while the FIFO was empty
o_timeout  output  1  sticky; the timeout fired

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, incrementing value 0, LFSR 16'hACE1. Reset mid-run aborts immediately; no state is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on i_start.
  - RUN to DRAIN when the burst is complete (o_tx_count equals i_burst_len, nonzero) or on i_stop.
  - DRAIN to DONE when the FIFO is empty.
  - RUN or DRAIN to DONE on timeout.
  - DONE to RUN on i_start.
- Run start: i_mode and i_burst_len are sampled on entry to RUN. Counters, sticky flags, the FIFO and the generator are cleared on entry to RUN, in the same cycle.
- TX handshake:
  - o_tx_valid rises only in RUN, only when the FIFO count is below P_FIFO_DEPTH, and only when burst words remain.
  - Once high, o_tx_valid and o_tx_data stay stable until the handshake (o_tx_valid and i_tx_ready both high).
  - i_stop does not withdraw a pending valid. The pending word completes, then the FSM enters DRAIN.
  - On a handshake: push o_tx_data into the FIFO, increment o_tx_count, advance the generator.
  - o_tx_valid drops in the cycle after the final burst handshake.
- Generator:
  - Mode 0: value increments by 1 modulo 2^P_DATA_WIDTH; first word is 0.
  - Mode 1: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB, feedback into bit 0. o_tx_data is LFSR[P_DATA_WIDTH-1:0]. First word is from the seed (8'hE1 at width 8).
- RX check:
  - On i_rx_valid in RUN or DRAIN: increment o_rx_count.
  - If the FIFO is non-empty: pop the head and compare it with i_rx_data; a mismatch increments o_err_count.
  - If the FIFO is empty: set o_unexpected and increment o_err_count.
  - i_rx_valid in IDLE or DONE is ignored.
- Push and pop in the same cycle: the FIFO count is unchanged, and the head is compared before the new word lands. This is valid at count = P_FIFO_DEPTH-1 and at count = 1. A push at count = P_FIFO_DEPTH cannot occur by construction.
- Timeout:
  - The idle counter clears on every i_rx_valid and whenever the FIFO is empty.
  - It increments while the FIFO is non-empty in RUN or DRAIN.
  - Reaching P_TIMEOUT_CYCLES sets o_timeout, forces DONE, drops o_tx_valid and flushes the FIFO.
- Counters: o_tx_count and o_rx_count wrap modulo 2^P_CNT_WIDTH; o_err_count saturates.
- Output timing: status outputs are registered and update the cycle after their causing event.

Test Plan:
1. Loopback through the UART driver, mode 0, i_burst_len=16 -> words 0..15 sent; DONE with o_tx_count=16, o_rx_count=16, o_err_count=0, o_pass=1.
2. Mode 1, burst 4, P_DATA_WIDTH=8, ideal loopback -> first o_tx_data=8'hE1, subsequent words match the LFSR reference model; o_pass=1.
3. Bench holds i_tx_ready high and delays RX returns, P_FIFO_DEPTH=4 -> o_tx_valid low while 4 words are outstanding; resumes after one i_rx_valid; same-cycle push/pop leaves the count at 3 or 4 correctly.
4. Bench flips bit 0 of the 3rd returned word, burst 8 -> o_err_count=1, o_pass=0; the run still completes with o_rx_count=8.
5. i_rx_valid pulsed while the FIFO is empty in RUN -> o_unexpected=1, o_err_count=1. Separately, drop the RX path with P_TIMEOUT_CYCLES=1000 -> o_timeout=1 and DONE 1000 cycles after the last activity.
6. Continuous mode (burst 0), i_stop mid-handshake, then reset asserted mid-DRAIN on a second run -> pending word completes and drains to DONE with o_pass=1; reset returns all outputs to 0 and the FSM to IDLE.
